regfile_sb: RTL and testbench

Parametrised successor register file for the RV32I core with a built-in scoreboard.
- Data and address widths are parameters; x0 is hardwired to zero; all registers clear on reset.
- Write-to-read bypass makes a same-cycle writeback visible on the read ports.
- A pending-bit scoreboard tracks in-flight destination registers and raises a stall for RAW and WAW hazards.
- Sits between decode/issue (read and issue side) and writeback (write side).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 56 +++++
 rtl/regfile_sb.sv | 71 +++++++
 tb/tb_regfile_sb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, special register indices and address/data typedefs for the
// RV32I register file with scoreboard.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO   = 0;
  localparam int REG_A0     = 10;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: tracks in-flight destination registers and flags
// RAW/WAW hazards for the instruction presented at issue.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   pending_cnt
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0] pending;
  logic rs1_hit, rs2_hit, issue_hit, dest_busy;
  logic set, clr, inc, dec;

  // A writeback landing this cycle resolves the matching pending bit early.
  assign rs1_hit   = wb_en && (wb_addr == rs1_addr) && (rs1_addr != '0);
  assign rs2_hit   = wb_en && (wb_addr == rs2_addr) && (rs2_addr != '0);
  assign issue_hit = wb_en && (wb_addr == issue_addr) && (issue_addr != '0);

  assign rs1_busy  = pending[rs1_addr] && !rs1_hit;
  assign rs2_busy  = pending[rs2_addr] && !rs2_hit;
  assign dest_busy = (issue_addr != '0) && pending[issue_addr] && !issue_hit;

  // Issue handshake: issue_en is valid, !stall is ready; the instruction is
  // taken on a cycle where issue_en && !stall, and must hold otherwise.
  assign stall = !rst && issue_en && (rs1_busy || rs2_busy || dest_busy);
  assign set   = !rst && issue_en && !stall && (issue_addr != '0);
  assign clr   = wb_en && (wb_addr != '0);

  // Count deltas follow the actual bit transitions so pending_cnt stays the popcount.
  assign inc = set && !pending[issue_addr];
  assign dec = clr && pending[wb_addr] && !(set && (issue_addr == wb_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      if (clr) pending[wb_addr] <= 1'b0;
      if (set) pending[issue_addr] <= 1'b1;
      pending_cnt <= pending_cnt + {{ADDR_WIDTH{1'b0}}, inc} - {{ADDR_WIDTH{1'b0}}, dec};
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Register file with x0 hardwired to zero, write-to-read bypass, a registered
// a0 mirror, and the pending-bit scoreboard for issue hazards.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int A0_IDX     = REG_A0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   pending_cnt,
  output logic [DATA_WIDTH-1:0] a0
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_SEL = ADDR_WIDTH'(A0_IDX);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0) rs1_data = '0;
    else if (wb_en && (wb_addr == rs1_addr)) rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0) rs2_data = '0;
    else if (wb_en && (wb_addr == rs2_addr)) rs2_data = wb_data;
  end

  // Mirror is the stored value only; a same-cycle writeback shows up next cycle.
  assign a0 = regs[A0_SEL];

  regfile_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .stall      (stall),
    .pending_cnt(pending_cnt)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected values are queued with each step and
// popped in order when the outputs are sampled.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic        rs1_busy, rs2_busy, stall;
  logic [5:0]  pending_cnt;
  logic [31:0] a0;

  logic [31:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall),
    .pending_cnt(pending_cnt), .a0(a0)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia);
    rs1_addr = r1; rs2_addr = r2;
    wb_en = we; wb_addr = wa; wb_data = wd;
    issue_en = ie; issue_addr = ia;
  endtask

  // scoreboard
  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: observed %0h with empty expected queue", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  initial begin
    // reset: issue during reset is ignored
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    expect_val(32'd0); expect_val(32'd0); expect_val(32'd0); expect_val(32'd0);
    sample();
    chk("rst_cnt", 32'(pending_cnt));
    chk("rst_stall", 32'(stall));
    chk("rst_rs1", rs1_data);
    chk("rst_a0", a0);
    tick();
    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_val(32'd0);
    sample();
    chk("post_rst_cnt", 32'(pending_cnt));

    // write then read
    tick();
    drive(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    tick();
    drive(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_val(32'hDEADBEEF); expect_val(32'd0); expect_val(32'd0);
    sample();
    chk("rd_x5", rs1_data);
    chk("rd_x0", rs2_data);
    chk("rd_cnt", 32'(pending_cnt));

    // bypass and x0 writes
    tick();
    drive(5'd7, 5'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
    expect_val(32'h1234);
    sample();
    chk("bypass_x7", rs1_data);
    tick();
    drive(5'd7, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
    expect_val(32'h1234); expect_val(32'd0);
    sample();
    chk("stored_x7", rs1_data);
    chk("x0_bypass", rs2_data);
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_val(32'd0);
    sample();
    chk("x0_stored", rs1_data);

    // RAW stall
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    expect_val(32'd0);
    sample();
    chk("raw_issue_stall", 32'(stall));
    tick();
    drive(5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    expect_val(32'd1); expect_val(32'd1); expect_val(32'd1);
    sample();
    chk("raw_cnt1", 32'(pending_cnt));
    chk("raw_busy", 32'(rs1_busy));
    chk("raw_stall", 32'(stall));
    tick();
    drive(5'd3, 5'd0, 1'b1, 5'd3, 32'h55, 1'b1, 5'd0);
    expect_val(32'd1); expect_val(32'd0); expect_val(32'd0); expect_val(32'h55);
    sample();
    chk("raw_held_cnt", 32'(pending_cnt));
    chk("raw_res_busy", 32'(rs1_busy));
    chk("raw_res_stall", 32'(stall));
    chk("raw_res_data", rs1_data);
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_val(32'd0);
    sample();
    chk("raw_clr_cnt", 32'(pending_cnt));

    // WAW and set-wins
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    expect_val(32'd0);
    sample();
    chk("waw_first", 32'(stall));
    tick();
    expect_val(32'd1); expect_val(32'd1);
    sample();
    chk("waw_stall", 32'(stall));
    chk("waw_cnt", 32'(pending_cnt));
    tick();
    drive(5'd0, 5'd0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
    expect_val(32'd0);
    sample();
    chk("setwin_accept", 32'(stall));
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    expect_val(32'd1); expect_val(32'd1);
    sample();
    chk("setwin_cnt", 32'(pending_cnt));
    chk("setwin_still_pend", 32'(stall));
    tick();
    drive(5'd0, 5'd0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_val(32'd0);
    sample();
    chk("waw_clr_cnt", 32'(pending_cnt));

    // count tracking
    for (int r = 1; r <= 3; r++) begin
      tick();
      drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(r));
    end
    tick();
    drive(5'd2, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_val(32'd3); expect_val(32'd1); expect_val(32'd0);
    sample();
    chk("cnt3", 32'(pending_cnt));
    chk("busy_no_issue", 32'(rs1_busy));
    chk("stall_no_issue", 32'(stall));
    tick();
    drive(5'd0, 5'd0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd6);
    tick();
    drive(5'd0, 5'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    expect_val(32'd3);
    sample();
    chk("cnt_swap", 32'(pending_cnt));
    tick();
    drive(5'd0, 5'd0, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0);
    expect_val(32'd3); expect_val(32'd0);
    sample();
    chk("cnt_nonpend_wb", 32'(pending_cnt));
    chk("a0_no_bypass", a0);
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_val(32'hA0);
    sample();
    chk("a0_mirror", a0);

    // async reset between edges, with x2,x3,x6 pending
    tick();
    drive(5'd5, 5'd10, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    #1;
    expect_val(32'd1);
    chk("pre_rst_stall", 32'(stall));
    #1;
    rst = 1'b1;
    #1;
    expect_val(32'd0); expect_val(32'd0); expect_val(32'd0);
    expect_val(32'd0); expect_val(32'd0); expect_val(32'd0);
    chk("arst_cnt", 32'(pending_cnt));
    chk("arst_stall", 32'(stall));
    chk("arst_busy", 32'(rs1_busy));
    chk("arst_a0", a0);
    chk("arst_rs1", rs1_data);
    chk("arst_rs2", rs2_data);
    tick();
    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();

    // final report
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d expected values never compared", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
